// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// 640x480@60 defaults, per-axis total, counter-width sufficiency check.
package vga_timing_pkg;

    localparam int DEF_CNT_W    = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_H_POL    = 1'b0;
    localparam bit DEF_V_POL    = 1'b0;

    function automatic int axis_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic bit cnt_w_fits(
        input int cnt_w,
        input int h_total,
        input int v_total
    );
        return (h_total <= (1 << cnt_w))
            && (v_total <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the generator to renderer and pins.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             h_visible;
    logic             v_visible;
    logic             de;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync,
        output h_visible, v_visible, de,
        output line_start, frame_start, frame_cnt
    );
    modport slave (
        input hcount, vcount, hsync, vsync,
        input h_visible, v_visible, de,
        input line_start, frame_start, frame_cnt
    );
`else
    modport master (
        output hcount, vcount, hsync, vsync,
        output h_visible, v_visible, de,
        output line_start, frame_start
    );
    modport slave (
        input hcount, vcount, hsync, vsync,
        input h_visible, v_visible, de,
        input line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter plus flags decoded from the
// next count so they are registered alongside it.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = DEF_H_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             visible,
    output logic             wrap,
    output logic             first
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
    localparam logic [31:0] ACT_END = 32'(ACTIVE);
    localparam logic [31:0] SYNC_LO = 32'(ACTIVE + FP);
    localparam logic [31:0] SYNC_HI = 32'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      nxt_w;
    logic             in_sync;

    always_comb begin
        cnt_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
        nxt_w   = 32'(cnt_nxt);
        in_sync = (nxt_w >= SYNC_LO) && (nxt_w < SYNC_HI);
    end

    // Reset parks on the last position so the first advance is (0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= LAST;
            sync    <= ~POL;
            visible <= 1'b0;
            wrap    <= 1'b1;
            first   <= 1'b0;
        end else if (adv) begin
            count   <= cnt_nxt;
            sync    <= in_sync ? POL : ~POL;
            visible <= nxt_w < ACT_END;
            wrap    <= cnt_nxt == LAST;
            first   <= cnt_nxt == '0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (two axis timers).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = DEF_H_POL,
    parameter bit V_POL    = DEF_V_POL
) (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic ce,
    vga_timing_if.master vif
);
    localparam int H_TOTAL =
        axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL =
        axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (!cnt_w_fits(CNT_W, H_TOTAL, V_TOTAL)) begin : g_cnt_w_bad
        $error("vga_timing_gen: CNT_W too narrow");
    end

    logic h_wrap;
    logic h_first;
    logic v_wrap;
    logic v_first;
    logic v_adv;

    assign v_adv = ce & h_wrap;

    vga_axis_timer #(
        .CNT_W  (CNT_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h (
        .clk     (pixel_clk),
        .rst_n   (rst_n),
        .adv     (ce),
        .count   (vif.hcount),
        .sync    (vif.hsync),
        .visible (vif.h_visible),
        .wrap    (h_wrap),
        .first   (h_first)
    );

    vga_axis_timer #(
        .CNT_W  (CNT_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v (
        .clk     (pixel_clk),
        .rst_n   (rst_n),
        .adv     (v_adv),
        .count   (vif.vcount),
        .sync    (vif.vsync),
        .visible (vif.v_visible),
        .wrap    (v_wrap),
        .first   (v_first)
    );

    assign vif.de          = vif.h_visible & vif.v_visible;
    assign vif.line_start  = h_first;
    assign vif.frame_start = h_first & v_first;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Counts the edge that moves the raster from (last,last) to (0,0).
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (ce && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vif.frame_cnt = frame_cnt_q;
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets against a raster model,
// reset/ce vector table and sync/frame measurements.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb;
        bit hp;
        int va, vf, vs, vb;
        bit vp;
    } cfg_t;

    typedef logic [28:0] obs_t;

    typedef struct {
        logic r;
        logic c;
        int   h;
        int   v;
        logic hs, vs, de, ls, fs;
    } vec_t;

    logic pixel_clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_if #(.CNT_W(10)) if0 ();
    vga_timing_if #(.CNT_W(5))  if1 ();
    vga_timing_if #(.CNT_W(11)) if2 ();

    vga_timing_gen #(.CNT_W(10)) u0 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .vif       (if0)
    );

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) u1 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .vif       (if1)
    );

    vga_timing_gen #(
        .CNT_W(11), .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u2 (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .vif       (if2)
    );

    cfg_t cfg[3];
    int   mh[3];
    int   mv[3];
    obs_t sb0[$];
    obs_t sb1[$];
    obs_t sb2[$];
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t decode(cfg_t c, int h, int v);
        bit hs, vs, hv, vv;
        hv = h < c.ha;
        vv = v < c.va;
        hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        return {11'(h), 11'(v), hs, vs, hv, vv, hv & vv,
                h == 0, h == 0 && v == 0};
    endfunction

    function automatic obs_t observe(int d);
        case (d)
            0: return {11'(if0.hcount), 11'(if0.vcount), if0.hsync,
                       if0.vsync, if0.h_visible, if0.v_visible, if0.de,
                       if0.line_start, if0.frame_start};
            1: return {11'(if1.hcount), 11'(if1.vcount), if1.hsync,
                       if1.vsync, if1.h_visible, if1.v_visible, if1.de,
                       if1.line_start, if1.frame_start};
            default: return {11'(if2.hcount), 11'(if2.vcount), if2.hsync,
                       if2.vsync, if2.h_visible, if2.v_visible, if2.de,
                       if2.line_start, if2.frame_start};
        endcase
    endfunction

    task automatic model_step(int d, logic r, logic c);
        int ht, vt;
        ht = cfg[d].ha + cfg[d].hf + cfg[d].hs + cfg[d].hb;
        vt = cfg[d].va + cfg[d].vf + cfg[d].vs + cfg[d].vb;
        if (!r) begin
            mh[d] = ht - 1;
            mv[d] = vt - 1;
        end else if (c) begin
            if (mh[d] == ht - 1) begin
                mh[d] = 0;
                mv[d] = (mv[d] == vt - 1) ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
    endtask

    task automatic check(string name, int d, obs_t got, obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got=%h want=%h", name, d, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Drive on the falling edge, predict, then compare after the rise.
    task automatic cycle(logic r, logic c);
        obs_t e;
        @(negedge pixel_clk);
        rst_n = r;
        ce = c;
        for (int d = 0; d < 3; d++) begin
            model_step(d, r, c);
            case (d)
                0: sb0.push_back(decode(cfg[d], mh[d], mv[d]));
                1: sb1.push_back(decode(cfg[d], mh[d], mv[d]));
                default: sb2.push_back(decode(cfg[d], mh[d], mv[d]));
            endcase
        end
        @(posedge pixel_clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: e = sb0.pop_front();
                1: e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            check("scoreboard", d, observe(d), e);
        end
    endtask

    initial begin
        int fs_at[$];
        int rise_at[$];
        int de1, vs1lo, hs1hi;
        int big_first, big_len, def_first, def_len;
        int fcnt;
        bit prev_fs, found;

        cfg[0] = '{640, 16, 96, 48, 1'b0, 480, 10, 2, 33, 1'b0};
        cfg[1] = '{8, 2, 3, 3, 1'b1, 6, 1, 2, 1, 1'b0};
        cfg[2] = '{800, 40, 128, 88, 1'b1, 600, 1, 4, 23, 1'b1};
        for (int d = 0; d < 3; d++) begin
            mh[d] = 0;
            mv[d] = 0;
        end

        tbl[0] = '{1'b0, 1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].r, tbl[i].c);
            check("table", 0,
                29'({if0.hcount, if0.vcount, if0.hsync, if0.vsync,
                     if0.de, if0.line_start, if0.frame_start}),
                29'({10'(tbl[i].h), 10'(tbl[i].v), tbl[i].hs, tbl[i].vs,
                     tbl[i].de, tbl[i].ls, tbl[i].fs}));
        end

        // Continuous ce: frame period, de count, sync windows.
        de1 = 0; vs1lo = 0; fcnt = 0;
        big_first = -1; big_len = 0; def_first = -1; def_len = 0;
        cycle(1'b0, 1'b1);
        for (int n = 1; n <= 1200; n++) begin
            cycle(1'b1, 1'b1);
            if (if1.frame_start) fs_at.push_back(n);
            if (fs_at.size() == 1) begin
                if (if1.de) de1++;
                if (!if1.vsync) vs1lo++;
            end
            if (if2.vcount == 0 && if2.hsync) begin
                if (big_first < 0) big_first = int'(if2.hcount);
                big_len++;
            end
            if (if0.vcount == 0 && !if0.hsync) begin
                if (def_first < 0) def_first = int'(if0.hcount);
                def_len++;
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (if1.frame_start) begin
                fcnt++;
                check_int("frame_cnt_seq", int'(if1.frame_cnt), fcnt);
            end
`endif
        end
        if (fs_at.size() >= 2)
            check_int("frame_period", fs_at[1] - fs_at[0], 160);
        else
            check_int("frame_pulses", fs_at.size(), 2);
        check_int("de_per_frame", de1, 48);
        check_int("vsync_low_px", vs1lo, 32);
        check_int("big_hsync_start", big_first, 840);
        check_int("big_hsync_len", big_len, 128);
        check_int("def_hsync_start", def_first, 656);
        check_int("def_hsync_len", def_len, 96);

        // Alternating ce doubles periods in clocks.
        hs1hi = 0;
        prev_fs = 1'b0;
        cycle(1'b0, 1'b1);
        for (int n = 1; n <= 800; n++) begin
            cycle(1'b1, n % 2 == 1);
            if (if1.frame_start && !prev_fs) rise_at.push_back(n);
            prev_fs = if1.frame_start;
            if (rise_at.size() == 1 && if1.hsync) hs1hi++;
        end
        if (rise_at.size() >= 2)
            check_int("half_rate_period", rise_at[1] - rise_at[0], 320);
        else
            check_int("half_rate_pulses", rise_at.size(), 2);
        check_int("half_rate_hsync_clk", hs1hi, 60);

        // Random ce with occasional reset.
        for (int n = 0; n < 300; n++)
            cycle(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)));

        // Reset mid-frame at (5,3) on the small raster.
        cycle(1'b0, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            cycle(1'b1, 1'b1);
            found = (if1.hcount == 5'd5 && if1.vcount == 5'd3);
        end
        check_int("reach_mid_frame", int'(found), 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'(i % 2));
            check("mid_reset", 1, observe(1),
                  {11'd15, 11'd9, 7'b0100000});
        end
        cycle(1'b1, 1'b1);
        check("after_reset", 1, observe(1), {11'd0, 11'd0, 7'b0111111});

`ifdef VGA_TIMING_FRAME_CNT_EN
        force u1.frame_cnt_q = 16'hFFFF;
        #0;
        release u1.frame_cnt_q;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            cycle(1'b1, 1'b1);
            found = if1.frame_start;
        end
        check_int("frame_cnt_wrap", int'(if1.frame_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 hv counter.
- Front/sync/back porch widths, active size and sync polarity are set per axis; adds pixel-clock enable, synchronous reset, data-enable, and line/frame start strobes.
- Feeds snake-game pixel renderer and VGA output pins; all outputs registered and mutually aligned.

Parameters:
- CNT_W, 10, width of hcount/vcount; H_TOTAL and V_TOTAL must be <= 2**CNT_W.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- H_POL, 0, hsync active level (0 = active-low).
- V_POL, 0, vsync active level (0 = active-low).

Ports:
- pixel_clk  input  1  pixel clock, the block's only clock.
- rst_n  input  1  reset; synchronous, active-low.
- ce  input  1  pixel advance enable; 1 = advance one pixel this edge.
- hcount  output  CNT_W  horizontal position, 0..H_TOTAL-1.
- vcount  output  CNT_W  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync at H_POL level while asserted.
- vsync  output  1  vertical sync at V_POL level while asserted.
- h_visible  output  1  hcount < H_ACTIVE.
- v_visible  output  1  vcount < V_ACTIVE.
- de  output  1  h_visible AND v_visible.
- line_start  output  1  one-pixel strobe when hcount==0.
- frame_start  output  1  one-pixel strobe when hcount==0 AND vcount==0.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Sync windows: hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751). vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491). Outside these windows each sync sits at its inactive level (~POL).
- Reset: rst_n sampled low at a pixel_clk edge sets, regardless of ce:
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1;
  - hsync=~H_POL, vsync=~V_POL;
  - h_visible=v_visible=de=0, line_start=frame_start=0.
- Reset state equals the decode of the last raster position. The first ce edge after release lands on (0,0) with frame_start=1. Reset mid-frame aborts the frame immediately; no partial-line completion.
- Advance on edges with rst_n=1 and ce=1:
  - hcount<H_TOTAL-1: hcount+1.
  - hcount==H_TOTAL-1: hcount=0; vcount+1, or 0 if vcount==V_TOTAL-1.
- ce=0: every output holds its value. Strobes stay high across ce=0 cycles and are qualified by ce downstream.
- Alignment: all flag outputs are registered, decoded from next-state counters, so they always match the same-cycle hcount/vcount. Zero latency between counter and flags; no combinational path from inputs to outputs.
- Blocking assignments are not used in the sequential process.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0]. Reset value 0. Increments on every edge that sets frame_start; wraps 65535 -> 0. Used for blink/animation timing.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 defaults as named constants;
  - a function computing total = active+fp+sync+bp;
  - a constant function checking CNT_W sufficiency, which fails elaboration on overflow.
- Sub-module vga_axis_timer (one per axis, instantiated twice):
  - inputs: clk, rst_n, adv, and the axis parameters;
  - outputs: count, sync, visible, wrap, first.
- Horizontal instance: adv=ce. Vertical instance: adv = ce AND horizontal wrap.

Test Plan:
- Reset release, defaults, ce=1: cycle 0 shows hcount=799, vcount=524, de=0, hsync=vsync=1. Cycle 1 shows (0,0), de=1, frame_start=1, line_start=1.
- Full frame, defaults: exactly 420000 ce cycles between frame_start pulses; de high for 307200 of them; hsync low for 96 consecutive pixels starting at hcount=656; vsync low for 1600 pixels (2 lines) starting at vcount=490, hcount=0.
- ce toggled 1/0 alternately: outputs hold on ce=0 edges; frame period becomes 840000 clocks; sync widths double in clocks.
- rst_n pulsed low at (hcount=300, vcount=200) for 3 cycles: outputs equal reset values during and after reset; next ce edge gives (0,0) with frame_start=1.
- Override H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, H_POL=1, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, V_POL=1, CNT_W=11: H_TOTAL=1056, V_TOTAL=628; hsync high for hcount 840..967; vsync high for vcount 601..604.
- VGA_TIMING_FRAME_CNT_EN defined, 3 full frames from reset: frame_cnt reads 1, 2, 3 at successive frame_start edges. Force frame_cnt=65535 and cross one frame: reads 0.
